// File: rtl/match_scoreboard.sv
// Multi-player BCD match scoreboard: IDLE/PLAY/FINISH control, win-score detection and tie resolution.
// Define MATCH_TIMER_EN to build the tick-driven match timer; otherwise time_left is constant 0.
module match_scoreboard #(
   parameter int NUM_PLAYERS = 2,
   parameter int DIGITS      = 2,
   parameter int WIN_SCORE   = 10,
   parameter int TIME_LIMIT  = 90
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic [NUM_PLAYERS-1:0]          goal,
   input  logic                            tick,
   output logic [NUM_PLAYERS*DIGITS*4-1:0] score_bcd,
   output logic [1:0]                      state,
   output logic [NUM_PLAYERS-1:0]          winner,
   output logic                            tie,
   output logic [7:0]                      time_left
);
   localparam int SW = DIGITS * 4;
   localparam logic [1:0] S_IDLE   = 2'b00;
   localparam logic [1:0] S_PLAY   = 2'b01;
   localparam logic [1:0] S_FINISH = 2'b10;

   function automatic logic [SW-1:0] to_bcd(input int value);
      logic [SW-1:0] r;
      int v;
      r = '0;
      v = value;
      for (int d = 0; d < DIGITS; d++) begin
         r[d*4 +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
      logic [SW-1:0] r;
      logic carry;
      r = v;
      carry = 1'b1;
      for (int d = 0; d < DIGITS; d++) begin
         if (carry) begin
            if (v[d*4 +: 4] == 4'd9) begin
               r[d*4 +: 4] = 4'd0;
            end else begin
               r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Packed BCD orders the same as its decimal value, so plain unsigned compares work.
   localparam logic [SW-1:0] WIN_BCD = to_bcd(WIN_SCORE);
   localparam logic [SW-1:0] MAX_BCD = to_bcd(10**DIGITS - 1);

   logic [1:0]             state_reg, state_next;
   logic [SW-1:0]          score_reg  [NUM_PLAYERS];
   logic [SW-1:0]          score_next [NUM_PLAYERS];
   logic [SW-1:0]          max_score;
   logic [NUM_PLAYERS-1:0] at_max, reached;
   logic [NUM_PLAYERS-1:0] winner_reg, winner_next;
   logic                   tie_reg, tie_next;
   logic                   play, clear, win_hit, expire, decide;

   assign play    = (state_reg == S_PLAY);
   assign clear   = start && (state_reg != S_PLAY);
   assign win_hit = play && (|reached);
   assign decide  = win_hit || expire;

`ifdef MATCH_TIMER_EN
   logic [7:0] time_left_reg, time_left_next;

   always_comb begin
      time_left_next = time_left_reg;
      if (clear)
         time_left_next = 8'(TIME_LIMIT);
      else if (play && tick && time_left_reg != 8'd0)
         time_left_next = time_left_reg - 8'd1;
   end

   assign expire = play && tick && (time_left_reg == 8'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         time_left_reg <= 8'(TIME_LIMIT);
      else
         time_left_reg <= time_left_next;
   end

   assign time_left = time_left_reg;
`else
   logic unused_tick;
   localparam int unused_time_limit = TIME_LIMIT;
   assign unused_tick = tick;
   assign expire      = 1'b0;
   assign time_left   = 8'd0;
`endif

   always_comb begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         score_next[i] = score_reg[i];
         if (clear)
            score_next[i] = '0;
         else if (play && goal[i] && score_reg[i] != MAX_BCD)
            score_next[i] = bcd_inc(score_reg[i]);
      end
   end

   always_comb begin
      max_score = '0;
      for (int i = 0; i < NUM_PLAYERS; i++)
         if (score_next[i] > max_score)
            max_score = score_next[i];
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
         assign at_max[gi]              = (score_next[gi] == max_score);
         assign reached[gi]             = (score_next[gi] >= WIN_BCD);
         assign score_bcd[gi*SW +: SW]  = score_reg[gi];
      end
   endgenerate

   // When a win fires the maximum is itself >= WIN_SCORE, so at_max is exactly the winning set.
   always_comb begin
      winner_next = winner_reg;
      tie_next    = tie_reg;
      if (clear) begin
         winner_next = '0;
         tie_next    = 1'b0;
      end else if (decide) begin
         winner_next = at_max;
         tie_next    = |(at_max & (at_max - 1'b1));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_PLAYERS; i++)
            score_reg[i] <= '0;
         winner_reg <= '0;
         tie_reg    <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_PLAYERS; i++)
            score_reg[i] <= score_next[i];
         winner_reg <= winner_next;
         tie_reg    <= tie_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_reg <= S_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:   if (start)  state_next = S_PLAY;
         S_PLAY:   if (decide) state_next = S_FINISH;
         S_FINISH: if (start)  state_next = S_PLAY;
         default:              state_next = S_IDLE;
      endcase
   end

   always_comb begin
      state  = state_reg;
      winner = winner_reg;
      tie    = tie_reg;
   end
endmodule

// File: tb/tb_match_scoreboard.sv
// Directed bench for match_scoreboard: a 2-digit instance (a) and a 1-digit WIN_SCORE=9 instance (b).
module tb_match_scoreboard;
   logic        clk = 1'b0;
   logic        rst;
   logic        start_a, start_b, tick;
   logic [1:0]  goal_a, goal_b;
   logic [15:0] a_score;
   logic [1:0]  a_state, a_winner;
   logic        a_tie;
   logic [7:0]  a_time;
   logic [7:0]  b_score;
   logic [1:0]  b_state, b_winner;
   logic        b_tie;
   logic [7:0]  b_time;
   int          tests = 0;
   int          failed = 0;

`ifdef MATCH_TIMER_EN
   localparam logic [7:0] TL0 = 8'd3;
`else
   localparam logic [7:0] TL0 = 8'd0;
`endif

   always #5 clk = ~clk;

   match_scoreboard #(.NUM_PLAYERS(2), .DIGITS(2), .WIN_SCORE(10), .TIME_LIMIT(3)) u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .goal(goal_a), .tick(tick),
      .score_bcd(a_score), .state(a_state), .winner(a_winner), .tie(a_tie), .time_left(a_time)
   );

   match_scoreboard #(.NUM_PLAYERS(2), .DIGITS(1), .WIN_SCORE(9), .TIME_LIMIT(3)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .goal(goal_b), .tick(tick),
      .score_bcd(b_score), .state(b_state), .winner(b_winner), .tie(b_tie), .time_left(b_time)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_a(input string tag, input logic [15:0] sc, input logic [1:0] st,
                          input logic [1:0] w, input logic t);
      check({tag, ".score"},  32'(a_score),  32'(sc));
      check({tag, ".state"},  32'(a_state),  32'(st));
      check({tag, ".winner"}, 32'(a_winner), 32'(w));
      check({tag, ".tie"},    32'(a_tie),    32'(t));
      $display("[TB] %s: score=%h state=%b winner=%b tie=%b time_left=%0d",
               tag, a_score, a_state, a_winner, a_tie, a_time);
   endtask

   // One clock with the given inputs held, then all pulses dropped; sampled 1 ns after the edge.
   task automatic step(input logic sa, input logic [1:0] ga, input logic sb,
                       input logic [1:0] gb, input logic t);
      start_a = sa; goal_a = ga; start_b = sb; goal_b = gb; tick = t;
      @(posedge clk);
      #1;
      start_a = 1'b0; goal_a = 2'b00; start_b = 1'b0; goal_b = 2'b00; tick = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0; tick = 1'b0; goal_a = 2'b00; goal_b = 2'b00;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      check_a("reset_a", 16'h0000, 2'b00, 2'b00, 1'b0);
      check("reset_a.time", 32'(a_time), 32'(TL0));
      check("reset_b.score", 32'(b_score), 32'h0);
      check("reset_b.state", 32'(b_state), 32'h0);

      // Goals and tick in IDLE are ignored.
      step(1'b0, 2'b11, 1'b0, 2'b00, 1'b1);
      check_a("idle_goal", 16'h0000, 2'b00, 2'b00, 1'b0);
      check("idle_tick.time", 32'(a_time), 32'(TL0));

      // Goal coincident with accepted start is dropped.
      step(1'b1, 2'b01, 1'b0, 2'b00, 1'b0);
      check_a("start", 16'h0000, 2'b01, 2'b00, 1'b0);
      check("start.time", 32'(a_time), 32'(TL0));

      step(1'b1, 2'b00, 1'b0, 2'b00, 1'b0);
      check_a("start_in_play", 16'h0000, 2'b01, 2'b00, 1'b0);

      for (int k = 1; k <= 10; k++) begin
         step(1'b0, 2'b01, 1'b0, 2'b00, 1'b0);
         if (k < 10) check_a($sformatf("p0_goal%0d", k), 16'(k), 2'b01, 2'b00, 1'b0);
         else        check_a("p0_win", 16'h0010, 2'b10, 2'b01, 1'b0);
      end

      step(1'b0, 2'b11, 1'b0, 2'b00, 1'b0);
      check_a("finish_goal", 16'h0010, 2'b10, 2'b01, 1'b0);

      step(1'b1, 2'b00, 1'b0, 2'b00, 1'b0);
      check_a("restart", 16'h0000, 2'b01, 2'b00, 1'b0);

      repeat (9) step(1'b0, 2'b11, 1'b0, 2'b00, 1'b0);
      check_a("both9", 16'h0909, 2'b01, 2'b00, 1'b0);
      step(1'b0, 2'b11, 1'b0, 2'b00, 1'b0);
      check_a("tie_win", 16'h1010, 2'b10, 2'b11, 1'b1);

      // Asynchronous reset in the middle of a clock period.
      step(1'b1, 2'b00, 1'b0, 2'b00, 1'b0);
      repeat (3) step(1'b0, 2'b01, 1'b0, 2'b00, 1'b0);
      check_a("pre_rst", 16'h0003, 2'b01, 2'b00, 1'b0);
      #2 rst = 1'b1;
      #1;
      check_a("async_rst", 16'h0000, 2'b00, 2'b00, 1'b0);
      check("async_rst.time", 32'(a_time), 32'(TL0));
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      step(1'b1, 2'b00, 1'b0, 2'b00, 1'b0);
      check_a("post_rst_start", 16'h0000, 2'b01, 2'b00, 1'b0);

      // Instance b: 1 digit, WIN_SCORE 9, player 1 only.
      step(1'b0, 2'b00, 1'b1, 2'b00, 1'b0);
      check("b_start.state", 32'(b_state), 32'h1);
      for (int k = 1; k <= 12; k++) begin
         step(1'b0, 2'b00, 1'b0, 2'b10, 1'b0);
         check($sformatf("b_goal%0d.score", k), 32'(b_score), (k < 9) ? 32'(k << 4) : 32'h90);
         check($sformatf("b_goal%0d.state", k), 32'(b_state), (k < 9) ? 32'h1 : 32'h2);
         check($sformatf("b_goal%0d.winner", k), 32'(b_winner), (k < 9) ? 32'h0 : 32'h2);
         check($sformatf("b_goal%0d.tie", k), 32'(b_tie), 32'h0);
         $display("[TB] b_goal%0d: score=%h state=%b winner=%b", k, b_score, b_state, b_winner);
      end

      // Timer: instance a is in PLAY with 0:0; build a 2:1 lead, then tick.
      step(1'b0, 2'b01, 1'b0, 2'b00, 1'b0);
      step(1'b0, 2'b11, 1'b0, 2'b00, 1'b0);
      check_a("lead_2_1", 16'h0102, 2'b01, 2'b00, 1'b0);
      check("lead.time", 32'(a_time), 32'(TL0));
`ifdef MATCH_TIMER_EN
      step(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
      check("tick1.time", 32'(a_time), 32'd2);
      check("tick1.state", 32'(a_state), 32'h1);
      step(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
      check("tick2.time", 32'(a_time), 32'd1);
      check("tick2.state", 32'(a_state), 32'h1);
      step(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
      check("tick3.time", 32'(a_time), 32'd0);
      check_a("time_up", 16'h0102, 2'b10, 2'b01, 1'b0);
      step(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
      check("finish_tick.time", 32'(a_time), 32'd0);
      check_a("finish_tick", 16'h0102, 2'b10, 2'b01, 1'b0);
`else
      repeat (3) step(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
      check("no_timer.time", 32'(a_time), 32'd0);
      check_a("no_timer", 16'h0102, 2'b01, 2'b00, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
